// File: rtl/module_hamming_secded_decoder.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready handshakes
// on both sides and saturating single/double error counters.
module module_hamming_secded_decoder #(
   parameter int P     = 3,
   parameter int CNT_W = 16,
   localparam int unsigned N = (1 << P) - 1,
   localparam int unsigned K = N - P
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N:0]       in_codeword,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             correct_en,
   input  logic             cnt_clr,
   output logic [K-1:0]     out_data,
   output logic [P-1:0]     out_syndrome,
   output logic             out_err_single,
   output logic             out_err_double,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_single,
   output logic [CNT_W-1:0] cnt_double
);

   // Positions (1..N) that contribute to syndrome bit k.
   function automatic logic [N-1:0] syn_mask(input int unsigned k);
      logic [N-1:0] m;
      m = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         if (((i >> k) & 1) != 0) m = m | (N'(1) << (i - 1));
      end
      return m;
   endfunction

   // Hamming position of data bit d: the d-th non-power-of-two position.
   function automatic int unsigned data_pos(input int unsigned d);
      int unsigned cnt;
      int unsigned pos;
      cnt = 0;
      pos = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         if ((i & (i - 1)) != 0) begin
            if (cnt == d) pos = i;
            cnt++;
         end
      end
      return pos;
   endfunction

   logic [P-1:0] syn;
   logic         pa;
   logic [K-1:0] raw_data;

   logic         s1_valid;
   logic [K-1:0] s1_data;
   logic [P-1:0] s1_syn;
   logic         s1_pa;
   logic         s1_cen;
   logic [K-1:0] fixed_data;

   logic         s2_valid;
   logic         s1_ready;
   logic         out_hs;

   for (genvar k = 0; k < P; k++) begin : g_syn
      assign syn[k] = ^(in_codeword[N-1:0] & syn_mask(k));
   end

   assign pa = ^in_codeword;

   // Only the data positions are carried to stage 2; the check bits are fully
   // consumed by the syndrome and parity registered alongside them, and a
   // single-bit flip at a data position is equivalent to flipping the
   // codeword before extraction.
   for (genvar d = 0; d < K; d++) begin : g_data
      assign raw_data[d]   = in_codeword[data_pos(d) - 1];
      assign fixed_data[d] = s1_data[d] ^
                             (s1_pa && s1_cen && (s1_syn == P'(data_pos(d))));
   end

   assign s1_ready  = !s2_valid || out_ready;
   assign in_ready  = rst || !s1_valid || s1_ready;
   assign out_valid = s2_valid && !rst;
   assign out_hs    = out_valid && out_ready;

   // Stage 1: capture data bits, syndrome, overall parity and correct_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_pa    <= 1'b0;
         s1_cen   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= raw_data;
            s1_syn  <= syn;
            s1_pa   <= pa;
            s1_cen  <= correct_en;
         end
      end
   end

   // Stage 2: classify, apply correction and hold the result until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid       <= 1'b0;
         out_data       <= '0;
         out_syndrome   <= '0;
         out_err_single <= 1'b0;
         out_err_double <= 1'b0;
      end else if (s1_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data       <= fixed_data;
            out_syndrome   <= s1_syn;
            out_err_single <= s1_pa;
            out_err_double <= !s1_pa && (s1_syn != '0);
         end
      end
   end

   // Saturating error counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_single <= '0;
         cnt_double <= '0;
      end else if (out_hs) begin
         if (out_err_single && (cnt_single != '1)) cnt_single <= cnt_single + 1'b1;
         if (out_err_double && (cnt_double != '1)) cnt_double <= cnt_double + 1'b1;
      end
   end

endmodule

// File: tb/tb_module_hamming_secded_decoder.sv
// Self-checking bench: table vectors plus encoder-generated words, scoreboard
// queue, counter model for CNT_W=16 and CNT_W=2 instances fed in lockstep.
module tb_module_hamming_secded_decoder;

   logic       clk = 1'b0;
   logic       rst, in_valid, correct_en, cnt_clr, out_ready;
   logic [7:0] in_codeword;

   logic        in_ready, out_valid, out_err_single, out_err_double;
   logic [3:0]  out_data;
   logic [2:0]  out_syndrome;
   logic [15:0] cnt_single, cnt_double;

   logic        b_in_ready, b_out_valid, b_err_single, b_err_double;
   logic [3:0]  b_out_data;
   logic [2:0]  b_out_syndrome;
   logic [1:0]  b_cnt_single, b_cnt_double;

   always #5 clk = ~clk;

   module_hamming_secded_decoder #(.P(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_codeword(in_codeword), .in_valid(in_valid),
      .in_ready(in_ready), .correct_en(correct_en), .cnt_clr(cnt_clr),
      .out_data(out_data), .out_syndrome(out_syndrome),
      .out_err_single(out_err_single), .out_err_double(out_err_double),
      .out_valid(out_valid), .out_ready(out_ready),
      .cnt_single(cnt_single), .cnt_double(cnt_double));

   module_hamming_secded_decoder #(.P(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_codeword(in_codeword), .in_valid(in_valid),
      .in_ready(b_in_ready), .correct_en(correct_en), .cnt_clr(cnt_clr),
      .out_data(b_out_data), .out_syndrome(b_out_syndrome),
      .out_err_single(b_err_single), .out_err_double(b_err_double),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .cnt_single(b_cnt_single), .cnt_double(b_cnt_double));

   typedef struct {
      logic [7:0] code;
      logic       cen;
      logic [3:0] data;
      logic [2:0] syn;
      logic       es;
      logic       ed;
   } vec_t;

   typedef struct {
      vec_t v;
      int   cyc;
      bit   chk_lat;
   } sb_t;

   sb_t  q[$];
   vec_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   in_hs = 0;
   bit   lat_mode = 1'b1;
   int unsigned m_s16 = 0, m_d16 = 0, m_s2 = 0, m_d2 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      return {^c, c};
   endfunction

   function automatic logic [3:0] raw_data(input logic [7:0] c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

   // Build a word with nerr flips at positions a, b (1..8, 8 = overall parity).
   function automatic vec_t make_vec(input logic [3:0] d, input int nerr,
                                     input int a, input int b, input logic cen);
      vec_t v;
      int   sa, sb;
      v.code = encode(d);
      v.cen  = cen;
      v.es   = 1'b0;
      v.ed   = 1'b0;
      v.syn  = 3'd0;
      v.data = d;
      sa = (a < 8) ? a : 0;
      sb = (b < 8) ? b : 0;
      if (nerr >= 1) v.code = v.code ^ (8'h01 << (a - 1));
      if (nerr == 2) v.code = v.code ^ (8'h01 << (b - 1));
      if (nerr == 1) begin
         v.es   = 1'b1;
         v.syn  = 3'(sa);
         v.data = cen ? d : raw_data(v.code);
      end else if (nerr == 2) begin
         v.ed   = 1'b1;
         v.syn  = 3'(sa ^ sb);
         v.data = raw_data(v.code);
      end
      return v;
   endfunction

   // Monitor: counter model, scoreboard pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      sb_t e;
      cyc++;
      if (rst) begin
         q.delete();
         m_s16 = 0; m_d16 = 0; m_s2 = 0; m_d2 = 0;
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
         check("cnt_single", {16'd0, cnt_single}, m_s16);
         check("cnt_double", {16'd0, cnt_double}, m_d16);
         check("cnt2_single", {30'd0, b_cnt_single}, m_s2);
         check("cnt2_double", {30'd0, b_cnt_double}, m_d2);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               e = q.pop_front();
               check("out_data", {28'd0, out_data}, {28'd0, e.v.data});
               check("out_syndrome", {29'd0, out_syndrome}, {29'd0, e.v.syn});
               check("err_single", {31'd0, out_err_single}, {31'd0, e.v.es});
               check("err_double", {31'd0, out_err_double}, {31'd0, e.v.ed});
               check("d2_out_valid", {31'd0, b_out_valid}, 32'd1);
               check("d2_out_data", {28'd0, b_out_data}, {28'd0, e.v.data});
               check("d2_syndrome", {29'd0, b_out_syndrome}, {29'd0, e.v.syn});
               check("d2_flags", {30'd0, b_err_single, b_err_double}, {30'd0, e.v.es, e.v.ed});
               if (e.chk_lat) check("latency", cyc - e.cyc, 32'd2);
               if (e.v.es) begin
                  if (m_s16 != 65535) m_s16++;
                  if (m_s2 != 3) m_s2++;
               end
               if (e.v.ed) begin
                  if (m_d16 != 65535) m_d16++;
                  if (m_d2 != 3) m_d2++;
               end
            end
         end
         if (cnt_clr) begin
            m_s16 = 0; m_d16 = 0; m_s2 = 0; m_d2 = 0;
         end
         if (in_valid && in_ready) begin
            in_hs++;
            q.push_back('{v: cur, cyc: cyc, chk_lat: lat_mode});
         end
      end
   end

   // Called at posedge+#1; returns at posedge+#1 after the word is accepted.
   task automatic send(input vec_t v, output int waits);
      cur         = v;
      in_codeword = v.code;
      correct_en  = v.cen;
      in_valid    = 1'b1;
      waits       = 0;
      @(negedge clk);
      while (!in_ready && waits < 64) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk); #1;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain", q.size(), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t tbl[6];
      vec_t v;
      int   w, acc0, n, nerr, a, b;
      bit   done;

      tbl[0] = '{code: 8'h55, cen: 1'b1, data: 4'hB, syn: 3'b000, es: 1'b0, ed: 1'b0};
      tbl[1] = '{code: 8'h45, cen: 1'b1, data: 4'hB, syn: 3'b101, es: 1'b1, ed: 1'b0};
      tbl[2] = '{code: 8'h45, cen: 1'b0, data: 4'h9, syn: 3'b101, es: 1'b1, ed: 1'b0};
      tbl[3] = '{code: 8'hD5, cen: 1'b1, data: 4'hB, syn: 3'b000, es: 1'b1, ed: 1'b0};
      tbl[4] = '{code: 8'h41, cen: 1'b1, data: 4'h8, syn: 3'b110, es: 1'b0, ed: 1'b1};
      tbl[5] = '{code: 8'h41, cen: 1'b0, data: 4'h8, syn: 3'b110, es: 1'b0, ed: 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_codeword = 8'h00; correct_en = 1'b1;
      cnt_clr = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_out_data", {28'd0, out_data}, 32'd0);
      check("post_rst_syndrome", {29'd0, out_syndrome}, 32'd0);
      check("post_rst_flags", {30'd0, out_err_single, out_err_double}, 32'd0);
      check("post_rst_cnt", {cnt_single, cnt_double}, 32'd0);
      @(posedge clk); #1;

      // Table vectors, with explicit counter checks after the first two.
      for (int i = 0; i < 6; i++) begin
         send(tbl[i], w);
         if (i == 0) begin
            drain();
            check("clean_cnt", {cnt_single, cnt_double}, 32'd0);
         end
         if (i == 1) begin
            drain();
            check("single_cnt", {16'd0, cnt_single}, 32'd1);
            check("single_cnt_dbl", {16'd0, cnt_double}, 32'd0);
         end
      end
      drain();
      check("table_cnt_single", {16'd0, cnt_single}, 32'd3);
      check("table_cnt_double", {16'd0, cnt_double}, 32'd2);

      // Back-to-back stream with out_ready high: no input stalls, latency 2.
      for (int i = 0; i < 12; i++) begin
         nerr = $urandom_range(0, 2);
         a = $urandom_range(1, 8);
         do b = $urandom_range(1, 8); while (b == a);
         v = make_vec(4'($urandom_range(0, 15)), nerr, a, b, 1'($urandom_range(0, 1)));
         send(v, w);
         check("no_bubble", w, 32'd0);
      end
      drain();

      // Backpressure: three words offered while out_ready is low.
      lat_mode = 1'b0;
      out_ready = 1'b0;
      acc0 = in_hs;
      send(tbl[0], w);
      send(tbl[1], w);
      cur = tbl[4]; in_codeword = tbl[4].code; correct_en = tbl[4].cen; in_valid = 1'b1;
      repeat (3) begin @(negedge clk); #1; end
      check("bp_accepted", in_hs - acc0, 32'd2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_d2_in_ready", {31'd0, b_in_ready}, 32'd0);
      check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 16) begin n++; @(negedge clk); end
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      check("bp_total", in_hs - acc0, 32'd3);

      // Random out_ready throttling with encoder-generated words.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               nerr = $urandom_range(0, 2);
               a = $urandom_range(1, 8);
               do b = $urandom_range(1, 8); while (b == a);
               v = make_vec(4'($urandom_range(0, 15)), nerr, a, b, 1'($urandom_range(0, 1)));
               send(v, w);
            end
            done = 1'b1;
         end
         begin
            for (int t = 0; t < 4000 && !done; t++) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      lat_mode = 1'b1;

      // Mid-operation reset discards in-flight words.
      send(tbl[1], w);
      send(tbl[4], w);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("midrst_no_output", {31'd0, out_valid}, 32'd0);
         @(negedge clk); #1;
      end
      check("midrst_cnt", {cnt_single, cnt_double}, 32'd0);
      @(posedge clk); #1;

      // Small counter saturates at 3; clear wins over a same-cycle increment.
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(tbl[1], w);
      drain();
      check("sat_cnt2_single", {30'd0, b_cnt_single}, 32'd3);
      check("sat_cnt16_single", {16'd0, cnt_single}, 32'd5);
      cnt_clr = 1'b1;
      send(tbl[1], w);
      drain();
      check("clr_cnt2_single", {30'd0, b_cnt_single}, 32'd0);
      check("clr_cnt16_single", {16'd0, cnt_single}, 32'd0);
      cnt_clr = 1'b0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
